// File: rtl/ahb_apb_pkg.sv
// Shared AHB encodings and scheduler state type for the AHB-side blocks.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  localparam logic [1:0] HRESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } sched_state_t;

endpackage

// File: rtl/ahb_xfer_sched_if.sv
// Requester and AHB signal bundle for the transfer scheduler.
interface ahb_xfer_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  // Handshake: requester i raises req_valid[i] with req_write/addr/wdata stable
  // and holds it until req_gnt[i] pulses; the fields are captured on that
  // grant cycle. req_done[i] later pulses for one cycle with req_rdata/req_err.
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_gnt;
  logic [NUM_REQ-1:0]        req_done;
  logic [DATA_W-1:0]         req_rdata;
  logic                      req_err;
  logic                      busy;

  logic                      Hwrite;
  logic [1:0]                Htrans;
  logic [ADDR_W-1:0]         Haddr;
  logic [DATA_W-1:0]         Hwdata;
  logic                      Hreadyin;
  logic [DATA_W-1:0]         Hrdata;
  logic [1:0]                Hresp;
  logic                      Hreadyout;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, Hrdata, Hresp, Hreadyout,
    output req_gnt, req_done, req_rdata, req_err, busy,
           Hwrite, Htrans, Haddr, Hwdata, Hreadyin
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, Hrdata, Hresp, Hreadyout,
    input  req_gnt, req_done, req_rdata, req_err, busy,
           Hwrite, Htrans, Haddr, Hwdata, Hreadyin
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr wins.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  int j;

  // Scan from lowest to highest priority so the entry at ptr overwrites last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[j]) begin
        gnt_o = NUM_REQ'(1) << j;
        idx_o = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/ahb_xfer_sched.sv
// Round-robin scheduler issuing one single NONSEQ AHB transfer per accepted
// request, with a per-phase stall timeout.
module ahb_xfer_sched
  import ahb_apb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             Hclk,
  input  logic             Hreset,
  ahb_xfer_sched_if.master bus,
  output sched_state_t     dbg_state_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  sched_state_t       state_q;
  htrans_t            htrans_q;
  logic [IDX_W-1:0]   ptr_q, owner_q, win_idx;
  logic [NUM_REQ-1:0] win_oh, done_q, owner_oh;
  logic [CNT_W-1:0]   cnt_q;
  logic               hwrite_q, err_q, busy_q;
  logic [ADDR_W-1:0]  haddr_q;
  logic [DATA_W-1:0]  wdata_q, hwdata_q, rdata_q;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = bus.req_wdata[g*DATA_W +: DATA_W];
  end

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (win_oh),
    .idx_o (win_idx)
  );

  assign owner_oh = NUM_REQ'(1) << owner_q;

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q  <= ST_IDLE;
      htrans_q <= HT_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      hwrite_q <= 1'b0;
      haddr_q  <= '0;
      wdata_q  <= '0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|bus.req_valid) begin
            owner_q  <= win_idx;
            hwrite_q <= bus.req_write[win_idx];
            haddr_q  <= addr_arr[win_idx];
            wdata_q  <= wdata_arr[win_idx];
            htrans_q <= HT_NONSEQ;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ST_ADDR;
          end
        end
        ST_ADDR, ST_DATA: begin
          if (!bus.Hreadyout && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
            // Bridge never answered: abort the transfer and report an error.
            htrans_q <= HT_IDLE;
            rdata_q  <= '0;
            err_q    <= 1'b1;
            done_q   <= owner_oh;
            cnt_q    <= '0;
            state_q  <= ST_DONE;
          end else if (!bus.Hreadyout) begin
            cnt_q <= cnt_q + 1'b1;
          end else if (state_q == ST_ADDR) begin
            htrans_q <= HT_IDLE;
            hwdata_q <= hwrite_q ? wdata_q : '0;
            cnt_q    <= '0;
            state_q  <= ST_DATA;
          end else begin
            rdata_q <= hwrite_q ? '0 : bus.Hrdata;
            err_q   <= (bus.Hresp != HRESP_OKAY);
            done_q  <= owner_oh;
            cnt_q   <= '0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          ptr_q   <= (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Grant is a combinational view of the pick; the FSM latches on the same edge.
  assign bus.req_gnt   = (state_q == ST_IDLE && !Hreset) ? win_oh : '0;
  assign bus.req_done  = done_q;
  assign bus.req_rdata = rdata_q;
  assign bus.req_err   = err_q;
  assign bus.busy      = busy_q;
  assign bus.Hwrite    = hwrite_q;
  assign bus.Htrans    = htrans_q;
  assign bus.Haddr     = haddr_q;
  assign bus.Hwdata    = hwdata_q;
  assign bus.Hreadyin  = ~Hreset;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_ahb_xfer_sched.sv
// Directed bench for ahb_xfer_sched with hand-computed expected values.
module tb_ahb_xfer_sched;
  import ahb_apb_pkg::*;

  logic         Hclk;
  logic         Hreset;
  sched_state_t dbg_state;
  int           checks;
  int           passed;

  ahb_xfer_sched_if #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32)) bus ();

  ahb_xfer_sched #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .Hclk        (Hclk),
    .Hreset      (Hreset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic test_reset();
    Hreset = 1'b1;
    bus.req_valid = 4'hF;
    tick();
    tick();
    checks++; if (bus.req_gnt !== 4'b0000) $display("FAIL rst_gnt got=%b exp=0000", bus.req_gnt); else passed++;
    checks++; if (bus.Htrans !== 2'b00) $display("FAIL rst_htrans got=%b exp=00", bus.Htrans); else passed++;
    checks++; if (bus.Hwrite !== 1'b0) $display("FAIL rst_hwrite got=%b exp=0", bus.Hwrite); else passed++;
    checks++; if (bus.Haddr !== 32'h0) $display("FAIL rst_haddr got=%h exp=0", bus.Haddr); else passed++;
    checks++; if (bus.Hwdata !== 32'h0) $display("FAIL rst_hwdata got=%h exp=0", bus.Hwdata); else passed++;
    checks++; if (bus.req_done !== 4'b0000) $display("FAIL rst_done got=%b exp=0000", bus.req_done); else passed++;
    checks++; if (bus.req_rdata !== 32'h0) $display("FAIL rst_rdata got=%h exp=0", bus.req_rdata); else passed++;
    checks++; if (bus.req_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", bus.req_err); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.busy); else passed++;
    checks++; if (dbg_state !== ST_IDLE) $display("FAIL rst_state got=%0d exp=%0d", dbg_state, ST_IDLE); else passed++;
    bus.req_valid = 4'h0;
    Hreset = 1'b0;
    tick();
    checks++; if (bus.Hreadyin !== 1'b1) $display("FAIL rst_hreadyin got=%b exp=1", bus.Hreadyin); else passed++;
  endtask

  task automatic test_single_read();
    bus.req_write = 4'b0000;
    bus.req_addr[1*32 +: 32] = 32'h8000_0010;
    bus.Hrdata = 32'hDEAD_BEEF;
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_gnt !== 4'b0010) $display("FAIL rd_gnt got=%b exp=0010", bus.req_gnt); else passed++;
    tick();
    bus.req_valid = 4'b0000;
    checks++; if (bus.Htrans !== 2'b10) $display("FAIL rd_htrans_addr got=%b exp=10", bus.Htrans); else passed++;
    checks++; if (bus.Haddr !== 32'h8000_0010) $display("FAIL rd_haddr got=%h exp=80000010", bus.Haddr); else passed++;
    checks++; if (bus.Hwrite !== 1'b0) $display("FAIL rd_hwrite got=%b exp=0", bus.Hwrite); else passed++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL rd_busy got=%b exp=1", bus.busy); else passed++;
    checks++; if (bus.req_gnt !== 4'b0000) $display("FAIL rd_gnt_pulse got=%b exp=0000", bus.req_gnt); else passed++;
    tick();
    checks++; if (bus.Htrans !== 2'b00) $display("FAIL rd_htrans_data got=%b exp=00", bus.Htrans); else passed++;
    checks++; if (bus.Hwdata !== 32'h0) $display("FAIL rd_hwdata got=%h exp=0", bus.Hwdata); else passed++;
    checks++; if (bus.req_done !== 4'b0000) $display("FAIL rd_done_early got=%b exp=0000", bus.req_done); else passed++;
    tick();
    checks++; if (bus.req_done !== 4'b0010) $display("FAIL rd_done got=%b exp=0010", bus.req_done); else passed++;
    checks++; if (bus.req_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_rdata got=%h exp=deadbeef", bus.req_rdata); else passed++;
    checks++; if (bus.req_err !== 1'b0) $display("FAIL rd_err got=%b exp=0", bus.req_err); else passed++;
    tick();
    checks++; if (bus.req_done !== 4'b0000) $display("FAIL rd_done_pulse got=%b exp=0000", bus.req_done); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rd_busy_end got=%b exp=0", bus.busy); else passed++;
  endtask

  task automatic test_write_wait();
    bus.req_write = 4'b0100;
    bus.req_addr[2*32 +: 32] = 32'h8400_0004;
    bus.req_wdata[2*32 +: 32] = 32'h1234_5678;
    bus.req_valid = 4'b0100;
    #1;
    checks++; if (bus.req_gnt !== 4'b0100) $display("FAIL wr_gnt got=%b exp=0100", bus.req_gnt); else passed++;
    tick();
    bus.req_valid = 4'b0000;
    bus.req_wdata[2*32 +: 32] = 32'hFFFF_FFFF;
    bus.req_addr[2*32 +: 32] = 32'h0000_0000;
    checks++; if (bus.Hwrite !== 1'b1) $display("FAIL wr_hwrite got=%b exp=1", bus.Hwrite); else passed++;
    checks++; if (bus.Haddr !== 32'h8400_0004) $display("FAIL wr_haddr got=%h exp=84000004", bus.Haddr); else passed++;
    tick();
    bus.Hreadyout = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.Hwdata !== 32'h1234_5678) $display("FAIL wr_hwdata_wait%0d got=%h exp=12345678", i, bus.Hwdata); else passed++;
      checks++; if (bus.req_done !== 4'b0000) $display("FAIL wr_done_wait%0d got=%b exp=0000", i, bus.req_done); else passed++;
      tick();
    end
    bus.Hreadyout = 1'b1;
    checks++; if (bus.Hwdata !== 32'h1234_5678) $display("FAIL wr_hwdata_last got=%h exp=12345678", bus.Hwdata); else passed++;
    tick();
    checks++; if (bus.req_done !== 4'b0100) $display("FAIL wr_done got=%b exp=0100", bus.req_done); else passed++;
    checks++; if (bus.req_err !== 1'b0) $display("FAIL wr_err got=%b exp=0", bus.req_err); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] last_done;
    int cycles;
    Hreset = 1'b1;
    tick();
    Hreset = 1'b0;
    bus.req_write = 4'b0000;
    bus.req_valid = 4'hF;
    #1;
    last_done = 4'b0000;
    for (int g = 0; g < 5; g++) begin
      cycles = 0;
      while (bus.req_gnt == 4'b0000 && cycles < 20) begin
        if (bus.req_done != 4'b0000) last_done = bus.req_done;
        tick();
        cycles++;
      end
      checks++; if (bus.req_gnt !== exp_order[g]) $display("FAIL b2b_gnt%0d got=%b exp=%b", g, bus.req_gnt, exp_order[g]); else passed++;
      if (g > 0) begin
        checks++; if (last_done !== exp_order[g-1]) $display("FAIL b2b_done%0d got=%b exp=%b", g, last_done, exp_order[g-1]); else passed++;
        checks++; if (cycles !== 3) $display("FAIL b2b_gap%0d got=%0d exp=3", g, cycles); else passed++;
      end
      tick();
    end
    bus.req_valid = 4'h0;
    tick();
    tick();
    checks++; if (bus.req_done !== 4'b0001) $display("FAIL b2b_done_last got=%b exp=0001", bus.req_done); else passed++;
    tick();
    checks++; if (bus.busy !== 1'b0) $display("FAIL b2b_busy_end got=%b exp=0", bus.busy); else passed++;
  endtask

  task automatic test_timeout();
    bus.Hreadyout = 1'b0;
    bus.Hrdata = 32'h5555_AAAA;
    bus.req_write = 4'b0000;
    bus.req_addr[3*32 +: 32] = 32'h8800_0020;
    bus.req_valid = 4'b1000;
    #1;
    checks++; if (bus.req_gnt !== 4'b1000) $display("FAIL to_gnt got=%b exp=1000", bus.req_gnt); else passed++;
    tick();
    bus.req_valid = 4'b0000;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (bus.req_done !== 4'b0000 || bus.Htrans !== 2'b10) $display("FAIL to_stall%0d done=%b htrans=%b exp done=0000 htrans=10", i, bus.req_done, bus.Htrans); else passed++;
    end
    tick();
    checks++; if (bus.req_done !== 4'b1000) $display("FAIL to_done got=%b exp=1000", bus.req_done); else passed++;
    checks++; if (bus.req_err !== 1'b1) $display("FAIL to_err got=%b exp=1", bus.req_err); else passed++;
    checks++; if (bus.req_rdata !== 32'h0) $display("FAIL to_rdata got=%h exp=0", bus.req_rdata); else passed++;
    checks++; if (bus.Htrans !== 2'b00) $display("FAIL to_htrans got=%b exp=00", bus.Htrans); else passed++;
    bus.Hreadyout = 1'b1;
    tick();
    bus.Hrdata = 32'hA5A5_0001;
    bus.req_valid = 4'b0001;
    #1;
    checks++; if (bus.req_gnt !== 4'b0001) $display("FAIL to_next_gnt got=%b exp=0001", bus.req_gnt); else passed++;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    tick();
    checks++; if (bus.req_done !== 4'b0001) $display("FAIL to_next_done got=%b exp=0001", bus.req_done); else passed++;
    checks++; if (bus.req_rdata !== 32'hA5A5_0001) $display("FAIL to_next_rdata got=%h exp=a5a50001", bus.req_rdata); else passed++;
    checks++; if (bus.req_err !== 1'b0) $display("FAIL to_next_err got=%b exp=0", bus.req_err); else passed++;
    tick();
  endtask

  task automatic test_resp_err();
    bus.req_write = 4'b0000;
    bus.Hrdata = 32'hCAFE_F00D;
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_gnt !== 4'b0010) $display("FAIL re_gnt got=%b exp=0010", bus.req_gnt); else passed++;
    tick();
    bus.req_valid = 4'b0000;
    bus.Hresp = 2'b01;
    tick();
    tick();
    checks++; if (bus.req_done !== 4'b0010) $display("FAIL re_done got=%b exp=0010", bus.req_done); else passed++;
    checks++; if (bus.req_err !== 1'b1) $display("FAIL re_err got=%b exp=1", bus.req_err); else passed++;
    checks++; if (bus.req_rdata !== 32'hCAFE_F00D) $display("FAIL re_rdata got=%h exp=cafef00d", bus.req_rdata); else passed++;
    bus.Hresp = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.req_write = 4'b0100;
    bus.req_addr[2*32 +: 32] = 32'h8C00_0008;
    bus.req_wdata[2*32 +: 32] = 32'h0BAD_F00D;
    bus.req_valid = 4'b0100;
    #1;
    checks++; if (bus.req_gnt !== 4'b0100) $display("FAIL rm_gnt got=%b exp=0100", bus.req_gnt); else passed++;
    tick();
    bus.req_valid = 4'b0000;
    bus.Hreadyout = 1'b1;
    tick();
    bus.Hreadyout = 1'b0;
    checks++; if (dbg_state !== ST_DATA) $display("FAIL rm_state_data got=%0d exp=%0d", dbg_state, ST_DATA); else passed++;
    Hreset = 1'b1;
    tick();
    checks++; if (bus.req_done !== 4'b0000) $display("FAIL rm_done got=%b exp=0000", bus.req_done); else passed++;
    checks++; if (bus.Hwrite !== 1'b0 || bus.Haddr !== 32'h0 || bus.Hwdata !== 32'h0) $display("FAIL rm_ahb hwrite=%b haddr=%h hwdata=%h exp 0/0/0", bus.Hwrite, bus.Haddr, bus.Hwdata); else passed++;
    checks++; if (bus.busy !== 1'b0 || bus.Htrans !== 2'b00) $display("FAIL rm_busy_htrans busy=%b htrans=%b exp 0/00", bus.busy, bus.Htrans); else passed++;
    checks++; if (dbg_state !== ST_IDLE) $display("FAIL rm_state got=%0d exp=%0d", dbg_state, ST_IDLE); else passed++;
    Hreset = 1'b0;
    bus.Hreadyout = 1'b1;
    tick();
    checks++; if (bus.req_done !== 4'b0000) $display("FAIL rm_done_after got=%b exp=0000", bus.req_done); else passed++;
    bus.req_write = 4'b0000;
    bus.Hrdata = 32'h0000_0F0F;
    bus.req_valid = 4'hF;
    #1;
    checks++; if (bus.req_gnt !== 4'b0001) $display("FAIL rm_regnt got=%b exp=0001", bus.req_gnt); else passed++;
    tick();
    bus.req_valid = 4'h0;
    tick();
    tick();
    checks++; if (bus.req_done !== 4'b0001) $display("FAIL rm_redone got=%b exp=0001", bus.req_done); else passed++;
    tick();
  endtask

  initial begin
    checks = 0;
    passed = 0;
    Hreset = 1'b1;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.Hrdata = '0;
    bus.Hresp = 2'b00;
    bus.Hreadyout = 1'b1;
    test_reset();
    test_single_read();
    test_write_wait();
    test_back_to_back();
    test_timeout();
    test_resp_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
